// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - Y86-64 inter-stage pipeline register with stall, bubble, valid and sticky error.
// Optional PIPE_STAGE_REG_PERF_EN adds saturating stall/bubble event counters.
module pipe_stage_reg #(
    parameter int         W         = 64,
    parameter int         NWORD     = 5,
    parameter logic [3:0] NOP_ICODE = 4'h1,
    parameter logic [3:0] RNONE     = 4'hF,
    parameter logic [2:0] STAT_BUB  = 3'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 bubble,
    input  logic [2:0]           in_stat,
    input  logic [3:0]           in_icode,
    input  logic [3:0]           in_ifun,
    input  logic [3:0]           in_rA,
    input  logic [3:0]           in_rB,
    input  logic                 in_cnd,
    input  logic [NWORD*W-1:0]   in_data,
    output logic [2:0]           out_stat,
    output logic [3:0]           out_icode,
    output logic [3:0]           out_ifun,
    output logic [3:0]           out_rA,
    output logic [3:0]           out_rB,
    output logic                 out_cnd,
    output logic [NWORD*W-1:0]   out_data,
    output logic                 out_valid,
`ifdef PIPE_STAGE_REG_PERF_EN
    input  logic                 perf_clr,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_bubble_cnt,
`endif
    output logic                 err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_stat  <= STAT_BUB;
            out_icode <= NOP_ICODE;
            out_ifun  <= 4'h0;
            out_rA    <= RNONE;
            out_rB    <= RNONE;
            out_cnd   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else if (stall) begin
            // A bubble request during a stall is a control-unit bug: flag it, keep contents.
            if (bubble) begin
                err <= 1'b1;
            end
        end else if (bubble) begin
            out_stat  <= STAT_BUB;
            out_icode <= NOP_ICODE;
            out_ifun  <= 4'h0;
            out_rA    <= RNONE;
            out_rB    <= RNONE;
            out_cnd   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_stat  <= in_stat;
            out_icode <= in_icode;
            out_ifun  <= in_ifun;
            out_rA    <= in_rA;
            out_rB    <= in_rB;
            out_cnd   <= in_cnd;
            out_data  <= in_data;
            out_valid <= (in_stat != STAT_BUB);
        end
    end

`ifdef PIPE_STAGE_REG_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else if (perf_clr) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (!stall && bubble && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - Self-checking bench for pipe_stage_reg: vector table, corner sequences, random vs model.
module tb_pipe_stage_reg;
    localparam int W  = 64;
    localparam int NW = 5;
    localparam int DW = W * NW;

    logic          clk = 1'b0;
    logic          rst_n, stall, bubble, in_cnd;
    logic [2:0]    in_stat;
    logic [3:0]    in_icode, in_ifun, in_rA, in_rB;
    logic [DW-1:0] in_data;
    logic [2:0]    out_stat;
    logic [3:0]    out_icode, out_ifun, out_rA, out_rB;
    logic          out_cnd, out_valid, err;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_REG_PERF_EN
    logic          perf_clr;
    logic [31:0]   perf_stall_cnt, perf_bubble_cnt;
`endif

    int checks = 0;
    int passes = 0;

    pipe_stage_reg #(.W(W), .NWORD(NW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
        .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
        .in_rA(in_rA), .in_rB(in_rB), .in_cnd(in_cnd), .in_data(in_data),
        .out_stat(out_stat), .out_icode(out_icode), .out_ifun(out_ifun),
        .out_rA(out_rA), .out_rB(out_rB), .out_cnd(out_cnd), .out_data(out_data),
        .out_valid(out_valid),
`ifdef PIPE_STAGE_REG_PERF_EN
        .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [383:0] outs();
        return {43'b0, out_stat, out_icode, out_ifun, out_rA, out_rB, out_cnd, out_valid, out_data};
    endfunction

    // Everything a bubble/reset register should present, in the same packing as outs().
    function automatic logic [383:0] bubble_pack();
        return {43'b0, 3'd0, 4'h1, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, {DW{1'b0}}};
    endfunction

    typedef struct {
        logic        stall, bubble;
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] w0;
        logic [3:0]  e_icode;
        logic [2:0]  e_stat;
        logic [63:0] e_w0;
        logic [3:0]  e_rA;
        logic        e_cnd, e_valid, e_err;
    } vec_t;

    vec_t vt[13];

    // Reference model: the instruction record currently held by the stage.
    typedef struct {
        logic [2:0]    stat;
        logic [3:0]    icode, ifun, rA, rB;
        logic          cnd, valid;
        logic [DW-1:0] data;
    } rec_t;

    rec_t m;
    logic m_err;

    function automatic logic [383:0] pack_rec(input rec_t r);
        return {43'b0, r.stat, r.icode, r.ifun, r.rA, r.rB, r.cnd, r.valid, r.data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          st  bu  icode stat w0        e_icode e_stat e_w0      e_rA  cnd val err
        vt[0]  = '{1'b0,1'b0,4'h6,3'd1,64'h1234, 4'h6,3'd1,64'h1234, 4'h2,1'b1,1'b1,1'b0};
        vt[1]  = '{1'b0,1'b0,4'h3,3'd1,64'h33,   4'h3,3'd1,64'h33,   4'h2,1'b1,1'b1,1'b0};
        vt[2]  = '{1'b1,1'b0,4'h5,3'd1,64'h55,   4'h3,3'd1,64'h33,   4'h2,1'b1,1'b1,1'b0};
        vt[3]  = '{1'b1,1'b0,4'h5,3'd1,64'h55,   4'h3,3'd1,64'h33,   4'h2,1'b1,1'b1,1'b0};
        vt[4]  = '{1'b1,1'b0,4'h5,3'd1,64'h55,   4'h3,3'd1,64'h33,   4'h2,1'b1,1'b1,1'b0};
        vt[5]  = '{1'b0,1'b0,4'h5,3'd1,64'h55,   4'h5,3'd1,64'h55,   4'h2,1'b1,1'b1,1'b0};
        vt[6]  = '{1'b0,1'b0,4'h7,3'd2,64'h77,   4'h7,3'd2,64'h77,   4'h2,1'b1,1'b1,1'b0};
        vt[7]  = '{1'b0,1'b1,4'h9,3'd1,64'h99,   4'h1,3'd0,64'h0,    4'hF,1'b0,1'b0,1'b0};
        vt[8]  = '{1'b0,1'b0,4'h4,3'd0,64'h44,   4'h4,3'd0,64'h44,   4'h2,1'b1,1'b0,1'b0};
        vt[9]  = '{1'b0,1'b0,4'h2,3'd1,64'h22,   4'h2,3'd1,64'h22,   4'h2,1'b1,1'b1,1'b0};
        vt[10] = '{1'b1,1'b1,4'h8,3'd4,64'h88,   4'h2,3'd1,64'h22,   4'h2,1'b1,1'b1,1'b1};
        vt[11] = '{1'b0,1'b0,4'h6,3'd3,64'h66,   4'h6,3'd3,64'h66,   4'h2,1'b1,1'b1,1'b1};
        vt[12] = '{1'b0,1'b1,4'hA,3'd1,64'hAA,   4'h1,3'd0,64'h0,    4'hF,1'b0,1'b0,1'b1};

        rst_n = 1'b0; stall = 1'b0; bubble = 1'b0;
        in_stat = 3'd1; in_icode = 4'h0; in_ifun = 4'h0; in_rA = 4'h2; in_rB = 4'h3;
        in_cnd = 1'b1; in_data = '0;
`ifdef PIPE_STAGE_REG_PERF_EN
        perf_clr = 1'b0;
`endif
        step(); step();
        check("reset_outs", outs(), bubble_pack());
        check("reset_err", {383'b0, err}, 384'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            stall = vt[i].stall; bubble = vt[i].bubble;
            in_icode = vt[i].icode; in_stat = vt[i].stat;
            in_data = {{(DW-64){1'b0}}, vt[i].w0};
            step();
            check($sformatf("vec%0d_icode", i), {380'b0, out_icode}, {380'b0, vt[i].e_icode});
            check($sformatf("vec%0d_stat", i),  {381'b0, out_stat},  {381'b0, vt[i].e_stat});
            check($sformatf("vec%0d_rA", i),    {380'b0, out_rA},    {380'b0, vt[i].e_rA});
            check($sformatf("vec%0d_cnd", i),   {383'b0, out_cnd},   {383'b0, vt[i].e_cnd});
            check($sformatf("vec%0d_data", i),  {64'b0, out_data},   {320'b0, vt[i].e_w0});
            check($sformatf("vec%0d_valid", i), {383'b0, out_valid}, {383'b0, vt[i].e_valid});
            check($sformatf("vec%0d_err", i),   {383'b0, err},       {383'b0, vt[i].e_err});
        end

        // Reset in the middle of a stall, and no capture while reset is still low.
        stall = 1'b0; bubble = 1'b0; in_icode = 4'h6; in_stat = 3'd1;
        in_data = {DW{1'b1}};
        step();
        stall = 1'b1; in_icode = 4'hC;
        step();
        check("stall_hold_ones", {64'b0, out_data}, {64'b0, {DW{1'b1}}});
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_stall_outs", outs(), bubble_pack());
        check("reset_mid_stall_err", {383'b0, err}, 384'd0);
        stall = 1'b0;
        step();
        check("no_load_in_reset", outs(), bubble_pack());
        rst_n = 1'b1;
        step();
        check("load_after_reset", {380'b0, out_icode}, {380'b0, 4'hC});

`ifdef PIPE_STAGE_REG_PERF_EN
        perf_clr = 1'b1; step(); perf_clr = 1'b0;
        stall = 1'b1; repeat (4) step();
        stall = 1'b0; bubble = 1'b1; repeat (2) step();
        bubble = 1'b0;
        check("perf_stall4", {352'b0, perf_stall_cnt}, 384'd4);
        check("perf_bubble2", {352'b0, perf_bubble_cnt}, 384'd2);
        stall = 1'b1; perf_clr = 1'b1; step(); perf_clr = 1'b0;
        check("perf_clr_stall", {352'b0, perf_stall_cnt}, 384'd0);
        check("perf_clr_bubble", {352'b0, perf_bubble_cnt}, 384'd0);
        force dut.perf_stall_cnt = 32'hFFFF_FFFF;
        #1 release dut.perf_stall_cnt;
        step();
        check("perf_saturate", {352'b0, perf_stall_cnt}, {352'b0, 32'hFFFF_FFFF});
        stall = 1'b0;
`endif

        // Randomized run against the record model; restart from a clean reset.
        rst_n = 1'b0; #1;
        m = '{stat: 3'd0, icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF, cnd: 1'b0, valid: 1'b0, data: '0};
        m_err = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            bubble = ($urandom_range(0, 3) == 0);
            in_stat = 3'($urandom_range(0, 4));
            in_icode = 4'($urandom); in_ifun = 4'($urandom);
            in_rA = 4'($urandom); in_rB = 4'($urandom); in_cnd = 1'($urandom);
            for (int k = 0; k < DW / 32; k++) in_data[k*32 +: 32] = $urandom;
            @(posedge clk);
            if (stall) begin
                if (bubble) m_err = 1'b1;
            end else if (bubble) begin
                m = '{stat: 3'd0, icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF, cnd: 1'b0, valid: 1'b0, data: '0};
            end else begin
                m = '{stat: in_stat, icode: in_icode, ifun: in_ifun, rA: in_rA, rB: in_rB,
                      cnd: in_cnd, valid: (in_stat != 3'd0), data: in_data};
            end
            #1;
            check($sformatf("rand%0d_outs", c), outs(), pack_rec(m));
            check($sformatf("rand%0d_err", c), {383'b0, err}, {383'b0, m_err});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
